// File: rtl/config_pkg.sv
// Shared types and defaults for the configuration word sequencer.
package config_pkg;

    // Session decode states.
    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StWaitSync = 2'd1,
        StHeader   = 2'd2,
        StData     = 2'd3
    } seqState_t;

    // Source grant encodings, one-hot per source.
    typedef enum logic [1:0] {
        GrantNone = 2'b00,
        GrantUart = 2'b01,
        GrantBus  = 2'b10
    } grant_t;

    localparam logic [31:0] DefaultSyncWord       = 32'hFAB0_FAB1;
    localparam int unsigned DefaultDesyncFlag     = 20;
    localparam int unsigned DefaultNumberOfRows   = 16;
    localparam int unsigned DefaultRowSelectWidth = 5;

    // A header carrying the desync flag closes the session instead of opening a frame.
    function automatic logic isDesyncHeader(input logic [31:0] word, input int unsigned flagBit);
        logic [4:0] idx;
        idx = flagBit[4:0];
        return word[idx];
    endfunction

endpackage

// File: rtl/config_src_arbiter.sv
// Picks one configuration source (UART has priority), holds it for the whole
// session and presents the granted source's word/strobe to the sequencer.
module config_src_arbiter
    import config_pkg::*;
(
    input  logic        CLK,
    input  logic        resetn,
    input  logic        idle,
    input  logic        uartActive,
    input  logic        uartStrobe,
    input  logic [31:0] uartData,
    input  logic        busActive,
    input  logic        busStrobe,
    input  logic [31:0] busData,
    output logic [1:0]  grant,
    output logic        grantNew,
    output logic        activeLost,
    output logic        wordValid,
    output logic [31:0] word
);

    grant_t grant_q, grant_d;

    // Grant decision: only issued from idle, then held until the owner drops Active.
    always_comb begin
        grant_d    = grant_q;
        activeLost = ((grant_q == GrantUart) && !uartActive) ||
                     ((grant_q == GrantBus)  && !busActive);
        grantNew   = idle && (uartActive || busActive);
        if (idle) begin
            if (uartActive) begin
                grant_d = GrantUart;
            end else if (busActive) begin
                grant_d = GrantBus;
            end else begin
                grant_d = GrantNone;
            end
        end else if (activeLost) begin
            grant_d = GrantNone;
        end
    end

    // Word mux: the ungranted source is invisible; nothing passes while ungranted.
    always_comb begin
        wordValid = 1'b0;
        word      = '0;
        unique case (grant_q)
            GrantUart: begin
                wordValid = uartStrobe;
                word      = uartData;
            end
            GrantBus: begin
                wordValid = busStrobe;
                word      = busData;
            end
            default: begin
                wordValid = 1'b0;
                word      = '0;
            end
        endcase
    end

    // Grant register.
    always_ff @(posedge CLK) begin
        if (!resetn) begin
            grant_q <= GrantNone;
        end else begin
            grant_q <= grant_d;
        end
    end

    assign grant = grant_q;

endmodule

// File: rtl/config_word_sequencer.sv
// Decodes configuration sessions (sync word, then header + row-data records)
// from the granted loader and drives the fabric frame-write interface.
module config_word_sequencer
    import config_pkg::*;
#(
    parameter int unsigned NumberOfRows   = DefaultNumberOfRows,
    parameter int unsigned RowSelectWidth = DefaultRowSelectWidth,
    parameter logic [31:0] SyncWord       = DefaultSyncWord,
    parameter int unsigned DesyncFlag     = DefaultDesyncFlag
) (
    input  logic                      CLK,
    input  logic                      resetn,
    input  logic [31:0]               uart_WriteData,
    input  logic                      uart_WriteStrobe,
    input  logic                      uart_ComActive,
    input  logic [31:0]               bus_WriteData,
    input  logic                      bus_WriteStrobe,
    input  logic                      bus_Active,
    output logic [31:0]               FrameAddressRegister,
    output logic [31:0]               FrameData,
    output logic [RowSelectWidth-1:0] RowSelect,
    output logic                      RowWrite,
    output logic                      FrameStrobe,
    output logic [1:0]                Grant,
    output logic                      Busy,
    output logic                      Error,
    output logic [15:0]               FrameCount
);

    localparam logic [RowSelectWidth-1:0] LastRowIdx = RowSelectWidth'(NumberOfRows - 1);

    seqState_t                 state_q, state_d;
    logic [RowSelectWidth-1:0] rowCnt_q, rowCnt_d;
    logic [RowSelectWidth-1:0] rowSelect_q, rowSelect_d;
    logic [31:0]               frameAddr_q, frameAddr_d;
    logic [31:0]               frameData_q, frameData_d;
    logic                      rowWrite_q, rowWrite_d;
    logic                      strobePend_q, strobePend_d;
    logic                      frameStrobe_q, frameStrobe_d;
    logic                      error_q, error_d;
    logic [15:0]               frameCount_q, frameCount_d;

    logic                      grantNew;
    logic                      activeLost;
    logic                      wordValid;
    logic [31:0]               word;
    logic                      lastWord;

    config_src_arbiter u_arbiter (
        .CLK        (CLK),
        .resetn     (resetn),
        .idle       (state_q == StIdle),
        .uartActive (uart_ComActive),
        .uartStrobe (uart_WriteStrobe),
        .uartData   (uart_WriteData),
        .busActive  (bus_Active),
        .busStrobe  (bus_WriteStrobe),
        .busData    (bus_WriteData),
        .grant      (Grant),
        .grantNew   (grantNew),
        .activeLost (activeLost),
        .wordValid  (wordValid),
        .word       (word)
    );

    // The final row word of a frame; it completes the frame even if Active drops with it.
    assign lastWord = (state_q == StData) && wordValid && (rowCnt_q == '0);

    // Next-state and datapath: one transition per accepted word, session loss overrides.
    always_comb begin
        state_d       = state_q;
        rowCnt_d      = rowCnt_q;
        rowSelect_d   = rowSelect_q;
        frameAddr_d   = frameAddr_q;
        frameData_d   = frameData_q;
        rowWrite_d    = 1'b0;
        strobePend_d  = 1'b0;
        // FrameStrobe trails the last RowWrite by one cycle so the two never overlap.
        frameStrobe_d = strobePend_q;
        frameCount_d  = strobePend_q ? frameCount_q + 16'd1 : frameCount_q;
        error_d       = error_q;

        unique case (state_q)
            StIdle: begin
                if (grantNew) begin
                    state_d = StWaitSync;
                end
            end
            StWaitSync: begin
                if (wordValid && (word == SyncWord)) begin
                    state_d = StHeader;
                    error_d = 1'b0;
                end
            end
            StHeader: begin
                if (wordValid) begin
                    if (isDesyncHeader(word, DesyncFlag)) begin
                        state_d = StWaitSync;
                    end else begin
                        frameAddr_d = word;
                        rowCnt_d    = LastRowIdx;
                        state_d     = StData;
                    end
                end
            end
            StData: begin
                if (wordValid) begin
                    frameData_d = word;
                    rowSelect_d = rowCnt_q;
                    rowWrite_d  = 1'b1;
                    if (rowCnt_q == '0) begin
                        strobePend_d = 1'b1;
                        state_d      = StHeader;
                    end else begin
                        rowCnt_d = rowCnt_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if ((state_q != StIdle) && activeLost) begin
            state_d = StIdle;
            if (!lastWord) begin
                // Partial frame is abandoned: discard this cycle's word entirely.
                rowCnt_d     = rowCnt_q;
                rowSelect_d  = rowSelect_q;
                frameAddr_d  = frameAddr_q;
                frameData_d  = frameData_q;
                rowWrite_d   = 1'b0;
                strobePend_d = 1'b0;
                error_d      = (state_q == StData) ? 1'b1 : error_q;
            end
        end
    end

    // State and output registers, synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!resetn) begin
            state_q       <= StIdle;
            rowCnt_q      <= '0;
            rowSelect_q   <= '0;
            frameAddr_q   <= '0;
            frameData_q   <= '0;
            rowWrite_q    <= 1'b0;
            strobePend_q  <= 1'b0;
            frameStrobe_q <= 1'b0;
            error_q       <= 1'b0;
            frameCount_q  <= '0;
        end else begin
            state_q       <= state_d;
            rowCnt_q      <= rowCnt_d;
            rowSelect_q   <= rowSelect_d;
            frameAddr_q   <= frameAddr_d;
            frameData_q   <= frameData_d;
            rowWrite_q    <= rowWrite_d;
            strobePend_q  <= strobePend_d;
            frameStrobe_q <= frameStrobe_d;
            error_q       <= error_d;
            frameCount_q  <= frameCount_d;
        end
    end

    assign FrameAddressRegister = frameAddr_q;
    assign FrameData            = frameData_q;
    assign RowSelect            = rowSelect_q;
    assign RowWrite             = rowWrite_q;
    assign FrameStrobe          = frameStrobe_q;
    assign Busy                 = (state_q != StIdle);
    assign Error                = error_q;
    assign FrameCount           = frameCount_q;

    // Row writes and frame strobes must never coincide.
    always_ff @(posedge CLK) begin
        if (resetn) begin
            assert (!(rowWrite_q && frameStrobe_q));
        end
    end

endmodule
